// File: rtl/ysyx_25010008_pkg.sv
// Shared constants and types for the ysyx_25010008 decode/issue slice.
// The optional Zbb ANDN decode is controlled by YSYX_25010008_ANDN_EN in the issue stage.
package ysyx_25010008_pkg;

  localparam logic [7:0] ALU_ADD  = 8'h00;
  localparam logic [7:0] ALU_SUB  = 8'h01;
  localparam logic [7:0] ALU_XOR  = 8'h02;
  localparam logic [7:0] ALU_OR   = 8'h04;
  localparam logic [7:0] ALU_AND  = 8'h08;
  localparam logic [7:0] ALU_SLL  = 8'h10;
  localparam logic [7:0] ALU_SRL  = 8'h20;
  localparam logic [7:0] ALU_SRA  = 8'h40;
  localparam logic [7:0] ALU_ANDN = 8'h80;
  // Compares are the subtract bit plus one select bit.
  localparam logic [7:0] ALU_EQ   = 8'h03;
  localparam logic [7:0] ALU_NE   = 8'h05;
  localparam logic [7:0] ALU_LTU  = 8'h09;
  localparam logic [7:0] ALU_GEU  = 8'h11;
  localparam logic [7:0] ALU_LT   = 8'h21;
  localparam logic [7:0] ALU_GE   = 8'h41;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_SH,
    IMM_U,
    IMM_B
  } imm_fmt_e;

  typedef struct packed {
    logic [7:0]  alu_op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        is_branch;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        illegal;
  } issue_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_SH:  imm = {27'b0, inst[24:20]};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      default: imm = 32'b0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/ysyx_25010008_scoreboard.sv
// Per-register busy bits with one set port, two clear ports and two lookups.
// A set wins over any clear of the same register in the same cycle; x0 is never busy.
module ysyx_25010008_scoreboard
  import ysyx_25010008_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_i,
  input  logic [4:0] set_rd_i,
  input  logic       wb_clr_i,
  input  logic [4:0] wb_rd_i,
  input  logic       fl_clr_i,
  input  logic [4:0] fl_rd_i,
  input  logic [4:0] rs1_addr_i,
  input  logic [4:0] rs2_addr_i,
  output logic       rs1_busy_o,
  output logic       rs2_busy_o
);

  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (wb_clr_i) busy_d[wb_rd_i] = 1'b0;
    if (fl_clr_i) busy_d[fl_rd_i] = 1'b0;
    if (set_i)    busy_d[set_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Lookups see only the registered state, so a clear unblocks one cycle later.
  assign rs1_busy_o = busy_q[rs1_addr_i];
  assign rs2_busy_o = busy_q[rs2_addr_i];

endmodule

// File: rtl/ysyx_25010008_alu_issue.sv
// RV32I decode/issue stage: decodes, checks RAW hazards, and registers one ALU op.
// Define YSYX_25010008_ANDN_EN to decode Zbb ANDN; otherwise that encoding is illegal.
module ysyx_25010008_alu_issue
  import ysyx_25010008_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_alu_opcode,
  output logic [31:0] out_operand1,
  output logic [31:0] out_operand2,
  output logic [4:0]  out_rd,
  output logic        out_rd_wen,
  output logic        out_is_branch,
  output logic [31:0] out_imm,
  output logic [31:0] out_pc,
  output logic        out_illegal
);

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd;
  issue_t     dec;
  logic       rs1_used, rs2_used, writes, illegal;
  logic       rs1_busy, rs2_busy, hazard, accept;
  issue_t     slot_q, slot_d;
  logic       valid_q, valid_d;

  assign opc      = in_inst[6:0];
  assign rd       = in_inst[11:7];
  assign f3       = in_inst[14:12];
  assign f7       = in_inst[31:25];
  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];

  always_comb begin
    dec      = '0;
    dec.pc   = in_pc;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    writes   = 1'b0;
    illegal  = 1'b0;
    case (opc)
      OPC_OP: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        writes   = 1'b1;
        dec.op1  = rs1_data;
        dec.op2  = rs2_data;
        case ({f7, f3})
          {F7_BASE, 3'b000}: dec.alu_op = ALU_ADD;
          {F7_BASE, 3'b001}: dec.alu_op = ALU_SLL;
          {F7_BASE, 3'b010}: dec.alu_op = ALU_LT;
          {F7_BASE, 3'b011}: dec.alu_op = ALU_LTU;
          {F7_BASE, 3'b100}: dec.alu_op = ALU_XOR;
          {F7_BASE, 3'b101}: dec.alu_op = ALU_SRL;
          {F7_BASE, 3'b110}: dec.alu_op = ALU_OR;
          {F7_BASE, 3'b111}: dec.alu_op = ALU_AND;
          {F7_ALT,  3'b000}: dec.alu_op = ALU_SUB;
          {F7_ALT,  3'b101}: dec.alu_op = ALU_SRA;
`ifdef YSYX_25010008_ANDN_EN
          // The ALU computes ~op1 & op2, so swapping the sources yields rs1 & ~rs2.
          {F7_ALT,  3'b111}: begin
            dec.alu_op = ALU_ANDN;
            dec.op1    = rs2_data;
            dec.op2    = rs1_data;
          end
`else
          {F7_ALT,  3'b111}: illegal = 1'b1;
`endif
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        rs1_used = 1'b1;
        writes   = 1'b1;
        dec.op1  = rs1_data;
        dec.op2  = imm_gen(in_inst, IMM_I);
        case (f3)
          3'b000: dec.alu_op = ALU_ADD;
          3'b010: dec.alu_op = ALU_LT;
          3'b011: dec.alu_op = ALU_LTU;
          3'b100: dec.alu_op = ALU_XOR;
          3'b110: dec.alu_op = ALU_OR;
          3'b111: dec.alu_op = ALU_AND;
          3'b001: begin
            dec.op2 = imm_gen(in_inst, IMM_SH);
            if (f7 == F7_BASE) dec.alu_op = ALU_SLL;
            else               illegal = 1'b1;
          end
          default: begin
            dec.op2 = imm_gen(in_inst, IMM_SH);
            if (f7 == F7_BASE)     dec.alu_op = ALU_SRL;
            else if (f7 == F7_ALT) dec.alu_op = ALU_SRA;
            else                   illegal = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        writes  = 1'b1;
        dec.op2 = imm_gen(in_inst, IMM_U);
      end
      OPC_AUIPC: begin
        writes  = 1'b1;
        dec.op1 = in_pc;
        dec.op2 = imm_gen(in_inst, IMM_U);
      end
      OPC_BRANCH: begin
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
        dec.is_branch = 1'b1;
        dec.op1       = rs1_data;
        dec.op2       = rs2_data;
        dec.imm       = imm_gen(in_inst, IMM_B);
        case (f3)
          3'b000:  dec.alu_op = ALU_EQ;
          3'b001:  dec.alu_op = ALU_NE;
          3'b100:  dec.alu_op = ALU_LT;
          3'b101:  dec.alu_op = ALU_GE;
          3'b110:  dec.alu_op = ALU_LTU;
          3'b111:  dec.alu_op = ALU_GEU;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    // Illegal encodings issue as an inert bubble that reads and writes nothing.
    if (illegal) begin
      dec.alu_op    = ALU_ADD;
      dec.op1       = '0;
      dec.op2       = '0;
      dec.imm       = '0;
      dec.is_branch = 1'b0;
      writes        = 1'b0;
      rs1_used      = 1'b0;
      rs2_used      = 1'b0;
    end
    dec.illegal = illegal;
    dec.rd_wen  = writes & (rd != 5'd0);
    dec.rd      = dec.rd_wen ? rd : 5'd0;
  end

  assign hazard   = in_valid & ((rs1_used & rs1_busy) | (rs2_used & rs2_busy));
  assign in_ready = (!valid_q | out_ready) & !hazard & !flush;
  assign accept   = in_valid & in_ready;

  ysyx_25010008_scoreboard #(
    .NREG(NREG)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (accept & dec.rd_wen),
    .set_rd_i   (dec.rd),
    .wb_clr_i   (wb_valid),
    .wb_rd_i    (wb_rd),
    .fl_clr_i   (flush & valid_q & slot_q.rd_wen),
    .fl_rd_i    (slot_q.rd),
    .rs1_addr_i (rs1_addr),
    .rs2_addr_i (rs2_addr),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy)
  );

  // The slot drains and refills in the same cycle when execute consumes it.
  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      slot_d  = dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      slot_q  <= '0;
    end else begin
      valid_q <= valid_d;
      slot_q  <= slot_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_alu_opcode = slot_q.alu_op;
  assign out_operand1   = slot_q.op1;
  assign out_operand2   = slot_q.op2;
  assign out_rd         = slot_q.rd;
  assign out_rd_wen     = slot_q.rd_wen;
  assign out_is_branch  = slot_q.is_branch;
  assign out_imm        = slot_q.imm;
  assign out_pc         = slot_q.pc;
  assign out_illegal    = slot_q.illegal;

endmodule
